// File: rtl/imm_load_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// imm_load_pkg
// Shared definitions for the constant-load sequencer. A 32-bit constant is
// written as an upper write ({hi,16'h0}) followed by an OR-in write ({hi,lo}).
//   state_e  : sequencer states
//   OP_UPPER : wr_op code for the upper write
//   OP_OR    : wr_op code for the OR-in write
//   HALF_W   : width of one half of the constant
// ---------------------------------------------------------------------------
package imm_load_pkg;

    localparam int   HALF_W   = 16;
    localparam logic OP_UPPER = 1'b0;
    localparam logic OP_OR    = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/imm_load_sequencer_half_builder.sv
// ---------------------------------------------------------------------------
// imm_half_builder
// Combinational formatter for the register-file write data.
//   hi   : upper half of the constant
//   lo   : lower half of the constant
//   op   : OP_UPPER -> {hi, 16'h0}, OP_OR -> {hi, lo}
//   data : full 32-bit value to write
// ---------------------------------------------------------------------------
module imm_half_builder
    import imm_load_pkg::*;
(
    input  logic [HALF_W-1:0]   hi,
    input  logic [HALF_W-1:0]   lo,
    input  logic                op,
    output logic [2*HALF_W-1:0] data
);

    always_comb begin
        if (op == OP_UPPER) data = {hi, {HALF_W{1'b0}}};
        else                data = {hi, lo};
    end

endmodule

// File: rtl/imm_load_sequencer.sv
// ---------------------------------------------------------------------------
// imm_load_sequencer
// Loads a 32-bit constant into a register as an upper write followed by an
// OR-in of the lower half, sharing the register-file write port through a
// valid/grant handshake. Writes whose contribution is a zero half can be
// skipped, and every committed write is counted.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : constant-load request handshake
//   req_value, req_rd   : constant and destination register
//   wr_valid/wr_gnt     : write-port request and arbiter grant
//   wr_addr, wr_data    : registered write address and data
//   wr_op               : OP_UPPER or OP_OR
//   done                : one-cycle pulse when a request completes
//   busy                : high whenever not IDLE
//   wr_count            : committed writes since reset, wrapping
// ---------------------------------------------------------------------------
module imm_load_sequencer
    import imm_load_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter bit SKIP_ZERO_HALF = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_value,
    input  logic [ADDR_W-1:0] req_rd,
    output logic              wr_valid,
    input  logic              wr_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_op,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count
);

    state_e            state, state_nxt;
    logic [HALF_W-1:0] hi_q, lo_q, hi_nxt, lo_nxt;
    logic [ADDR_W-1:0] rd_q, rd_nxt;
    logic              accept, commit;
    logic              wr_valid_nxt, wr_op_nxt;
    logic [31:0]       wr_data_nxt;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = req_valid && req_ready;
    assign commit    = wr_valid && wr_gnt;

    // Next-state and latch logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        rd_nxt    = rd_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    hi_nxt = req_value[31:16];
                    lo_nxt = req_value[15:0];
                    rd_nxt = req_rd;
                    if (req_rd == '0)
                        state_nxt = DONE;
                    else if (SKIP_ZERO_HALF && (req_value[31:16] == '0))
                        state_nxt = WR_LO;
                    else
                        state_nxt = WR_HI;
                end
            end
            WR_HI: begin
                if (commit)
                    state_nxt = (SKIP_ZERO_HALF && (lo_q == '0)) ? DONE : WR_LO;
            end
            WR_LO: begin
                if (commit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The write-port outputs are computed from the next state so they appear
    // registered in the same cycle the state enters WR_HI/WR_LO. While stalled
    // nothing in the next-state view changes, so the outputs hold steady.
    assign wr_valid_nxt = (state_nxt == WR_HI) || (state_nxt == WR_LO);
    assign wr_op_nxt    = (state_nxt == WR_LO) ? OP_OR : OP_UPPER;

    imm_half_builder u_builder (
        .hi   (hi_nxt),
        .lo   (lo_nxt),
        .op   (wr_op_nxt),
        .data (wr_data_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the latched constant and destination are cleared on reset too,
        // so no stale request data survives an aborted sequence.
        if (!rst_n) begin
            state    <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            rd_q     <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_op    <= OP_UPPER;
            wr_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values regardless of ordering.
            state    <= state_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
            rd_q     <= rd_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= rd_nxt;
            wr_data  <= wr_data_nxt;
            wr_op    <= wr_op_nxt;
            if (commit) wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule
